gen_counter: RTL and testbench

Parametrised up/down counter for general event counting and timebase generation. It generalises the basic 4-bit enable counter with configurable width and modulus, direction control, parallel load, wrap or saturate mode, a built-in enable prescaler, and boundary status flags. Any datapath block that needs a programmable tick or event count instantiates it.

---
 rtl/cnt_pkg.sv | 7 +
 rtl/cnt_prescaler.sv | 36 +++
 rtl/gen_counter.sv | 76 +++++++
 tb/tb_gen_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared constants for the generic event/timebase counter family.
package cnt_pkg;
   localparam int   CNT_WRAP = 0;
   localparam int   CNT_SAT  = 1;
   localparam logic CNT_UP   = 1'b1;
   localparam logic CNT_DN   = 1'b0;
endpackage

// File: rtl/cnt_prescaler.sv
// Enable prescaler: emits one step every PRESCALE enabled cycles.
module cnt_prescaler
   import cnt_pkg::*;
#(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic sclr,
   output logic step
);

   generate
      if (PRESCALE == 1) begin : g_bypass
         logic unused_pins;
         assign unused_pins = &{1'b0, clk, rst, sclr};
         assign step        = en;
      end else begin : g_div
         localparam int PW = $clog2(PRESCALE);
         logic [PW-1:0] pcnt;
         logic          last;

         assign last = (pcnt == PW'(PRESCALE - 1));
         // A clear or load in the same cycle wins over the step.
         assign step = en & last & ~sclr;

         always_ff @(posedge clk or negedge rst) begin
            if (!rst)        pcnt <= '0;
            else if (sclr)   pcnt <= '0;
            else if (en)     pcnt <= last ? '0 : pcnt + PW'(1);
         end
      end
   endgenerate

endmodule

// File: rtl/gen_counter.sv
// Parametrised up/down counter with load, wrap/saturate, prescaler and boundary flags.
module gen_counter
   import cnt_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MAX_VAL  = 2**WIDTH - 1,
   parameter int SATURATE = 0,
   parameter int PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt_out,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

   logic             step;
   logic             boundary;
   logic [WIDTH-1:0] cnt_nxt;
   logic             wrap_nxt;
   logic             ovf_nxt;

   cnt_prescaler #(.PRESCALE(PRESCALE)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .sclr (clr | load),
      .step (step)
   );

   assign boundary = (up_dn == CNT_UP) ? (cnt_out == MAX) : (cnt_out == '0);
   assign tc       = boundary;

   always_comb begin
      cnt_nxt  = cnt_out;
      wrap_nxt = 1'b0;
      ovf_nxt  = ovf;
      if (clr) begin
         cnt_nxt = '0;
         ovf_nxt = 1'b0;
      end else if (load) begin
         cnt_nxt = (load_val > MAX) ? MAX : load_val;
      end else if (step) begin
         if (boundary) begin
            wrap_nxt = 1'b1;
            ovf_nxt  = 1'b1;
            // Saturating mode leaves the count parked at the boundary.
            if (SATURATE == CNT_WRAP)
               cnt_nxt = (up_dn == CNT_UP) ? '0 : MAX;
         end else begin
            cnt_nxt = (up_dn == CNT_UP) ? cnt_out + WIDTH'(1) : cnt_out - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_out <= '0;
         wrap    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         cnt_out <= cnt_nxt;
         wrap    <= wrap_nxt;
         ovf     <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_gen_counter.sv
// Randomised self-checking bench: three gen_counter variants against a behavioural model.
module tb_gen_counter;

   localparam int N  = 3;
   localparam int MX = 9;

   logic       clk = 1'b0;
   logic       rst, clr, en, up_dn, load;
   logic [3:0] load_val;
   logic [3:0] cnt  [N];
   logic       tc   [N];
   logic       wrap [N];
   logic       ovf  [N];

   int checks = 0;
   int errors = 0;

   // Instance 0: wrap, PRESCALE 1; 1: saturate; 2: wrap, PRESCALE 3.
   int sat_m [N] = '{0, 1, 0};
   int pre_m [N] = '{1, 1, 3};

   int m_cnt  [N];
   int m_pre  [N];
   bit m_wrap [N];
   bit m_ovf  [N];

   always #5 clk = ~clk;

   gen_counter #(.WIDTH(4), .MAX_VAL(MX), .SATURATE(0), .PRESCALE(1)) u_a (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .cnt_out(cnt[0]), .tc(tc[0]), .wrap(wrap[0]), .ovf(ovf[0]));
   gen_counter #(.WIDTH(4), .MAX_VAL(MX), .SATURATE(1), .PRESCALE(1)) u_b (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .cnt_out(cnt[1]), .tc(tc[1]), .wrap(wrap[1]), .ovf(ovf[1]));
   gen_counter #(.WIDTH(4), .MAX_VAL(MX), .SATURATE(0), .PRESCALE(3)) u_c (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .cnt_out(cnt[2]), .tc(tc[2]), .wrap(wrap[2]), .ovf(ovf[2]));

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: integer count, enabled-cycle tally for the prescaler.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N; i++) begin
            m_cnt[i]  <= 0;
            m_pre[i]  <= 0;
            m_wrap[i] <= 0;
            m_ovf[i]  <= 0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            int c, p;
            bit w, o;
            c = m_cnt[i]; p = m_pre[i]; w = 0; o = m_ovf[i];
            if (clr) begin
               c = 0; p = 0; o = 0;
            end else if (load) begin
               c = (int'(load_val) > MX) ? MX : int'(load_val);
               p = 0;
            end else if (en) begin
               p = p + 1;
               if (p == pre_m[i]) begin
                  p = 0;
                  if (up_dn) begin
                     if (c == MX) begin w = 1; o = 1; c = sat_m[i] ? MX : 0; end
                     else c = c + 1;
                  end else begin
                     if (c == 0) begin w = 1; o = 1; c = sat_m[i] ? 0 : MX; end
                     else c = c - 1;
                  end
               end
            end
            m_cnt[i]  <= c;
            m_pre[i]  <= p;
            m_wrap[i] <= w;
            m_ovf[i]  <= o;
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         chk($sformatf("cnt%0d", i),  int'(cnt[i]),  m_cnt[i]);
         chk($sformatf("wrap%0d", i), int'(wrap[i]), int'(m_wrap[i]));
         chk($sformatf("ovf%0d", i),  int'(ovf[i]),  int'(m_ovf[i]));
         chk($sformatf("tc%0d", i),   int'(tc[i]),
             int'((up_dn && m_cnt[i] == MX) || (!up_dn && m_cnt[i] == 0)));
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst = 0; clr = 0; en = 0; up_dn = 1; load = 0; load_val = 0;
      #3;
      chk("rst_cnt", int'(cnt[0]), 0);
      chk("rst_wrap", int'(wrap[0]), 0);
      chk("rst_ovf", int'(ovf[0]), 0);
      chk("rst_tc", int'(tc[0]), 0);
      tick();
      rst = 1;

      // Wrap-up through 9 -> 0.
      en = 1; up_dn = 1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("up_cnt", int'(cnt[0]), k % 10);
         chk("up_wrap", int'(wrap[0]), int'(k == 10));
         chk("up_tc", int'(tc[0]), int'(k == 9));
      end
      chk("up_ovf", int'(ovf[0]), 1);

      // Down-count wrap from 2.
      en = 0; load = 1; load_val = 2;
      tick();
      chk("ld_cnt", int'(cnt[0]), 2);
      load = 0; up_dn = 0; en = 1;
      tick(); chk("dn_cnt1", int'(cnt[0]), 1); chk("dn_wrap1", int'(wrap[0]), 0);
      tick(); chk("dn_cnt0", int'(cnt[0]), 0); chk("dn_tc0", int'(tc[0]), 1);
      tick(); chk("dn_cnt9", int'(cnt[0]), 9); chk("dn_wrap9", int'(wrap[0]), 1);

      // Saturation on instance 1.
      en = 0; load = 1; load_val = 8; up_dn = 1;
      tick();
      load = 0; en = 1;
      tick(); chk("sat_c1", int'(cnt[1]), 9); chk("sat_w1", int'(wrap[1]), 0);
      tick(); chk("sat_c2", int'(cnt[1]), 9); chk("sat_w2", int'(wrap[1]), 1);
      tick(); chk("sat_c3", int'(cnt[1]), 9); chk("sat_w3", int'(wrap[1]), 1);
      en = 0; load = 1; load_val = 0;
      tick();
      load = 0; up_dn = 0; en = 1;
      tick(); chk("sat_d1", int'(cnt[1]), 0); chk("sat_dw1", int'(wrap[1]), 1);
      tick(); chk("sat_d2", int'(cnt[1]), 0);

      // Priority and clamped load.
      clr = 1; load = 1; en = 1; load_val = 5;
      tick(); chk("pri_cnt", int'(cnt[0]), 0); chk("pri_ovf", int'(ovf[0]), 0);
      clr = 0; load_val = 15;
      tick(); chk("clamp_cnt", int'(cnt[0]), 9);
      load = 0;

      // Prescaler on instance 2.
      clr = 1; tick(); clr = 0; en = 1; up_dn = 1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk("pre_cnt", int'(cnt[2]), k / 3);
      end
      tick(); chk("pre_hold0", int'(cnt[2]), 3);
      en = 0;
      tick(); tick(); chk("pre_hold1", int'(cnt[2]), 3);
      en = 1;
      tick(); chk("pre_hold2", int'(cnt[2]), 3);
      tick(); chk("pre_step", int'(cnt[2]), 4);

      // Asynchronous reset mid-count.
      en = 0; load = 1; load_val = 9; tick();
      load = 0; en = 1; up_dn = 1; tick();
      en = 0; load = 1; load_val = 6; tick();
      load = 0;
      chk("ar_pre_cnt", int'(cnt[0]), 6);
      chk("ar_pre_ovf", int'(ovf[0]), 1);
      @(posedge clk); #3;
      rst = 0;
      #1;
      chk("ar_cnt", int'(cnt[0]), 0);
      chk("ar_ovf", int'(ovf[0]), 0);
      tick();
      rst = 1;

      // Randomised traffic, with occasional mid-cycle resets.
      for (int n = 0; n < 3000; n++) begin
         clr      = ($urandom % 25) == 0;
         load     = ($urandom % 12) == 0;
         en       = ($urandom % 4) != 0;
         up_dn    = ($urandom % 8) != 0 ? up_dn : ~up_dn;
         load_val = 4'($urandom % 16);
         tick();
         if (($urandom % 300) == 0) begin
            #2 rst = 0;
            #1 rst = 1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
